cp0_regs: RTL and testbench

Coprocessor-0 register block for the multi-cycle MIPS core, sitting directly downstream of the CPU's CP0 control outputs and feeding back `cp0_cpu_rdata`, `cp0_cpu_status` and `cp0_cpu_exc_addr`. It holds Status, Cause and EPC. It performs the exception-entry and `eret` state updates. It optionally provides a Count/Compare timer that raises a sticky interrupt request. All state changes occur on the clock edge in which the controller asserts the corresponding strobe.

---
 rtl/cp0_pkg.sv | 22 ++
 rtl/cp0_timer.sv | 34 +++
 rtl/cp0_regs.sv | 135 +++++++++++++
 tb/tb_cp0_regs.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 register block.
//   - CP0 register indices used by mfc0/mtc0 address decode
//   - ExcCode values the controller drives on the cause input
//   - Status and Cause bit positions
package cp0_pkg;

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;

   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_BREAK   = 5'd9;
   localparam logic [4:0] EXC_TEQ     = 5'd13;

   localparam int STATUS_IE  = 0;
   localparam int STATUS_EXL = 1;
   localparam int STATUS_IM7 = 15;
   localparam int CAUSE_IP7  = 15;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer pair for CP0 (built only with CP0_TIMER_EN).
// Ports:
//   clk, reset (async, active-low)
//   wr_count, wr_compare : mtc0 write enables for Count / Compare
//   wdata                : mtc0 write data
//   count, compare       : current register values
//   match                : Count == Compare with a non-zero Compare
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_count,
   input  logic        wr_compare,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        match
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count   <= '0;
         compare <= '0;
      end else begin
         // A Count write replaces the increment for that cycle; natural wrap.
         count <= wr_count ? wdata : count + 32'd1;
         if (wr_compare)
            compare <= wdata;
      end
   end

   // Compare == 0 is the "timer disarmed" value.
   assign match = (count == compare) && (compare != '0);

endmodule

// File: rtl/cp0_regs.sv
// cp0_regs: Coprocessor-0 register file (Status, Cause, EPC, optional
// Count/Compare) with exception-entry and eret updates.
// Optional feature macro: CP0_TIMER_EN (Count/Compare, IP7, timer_irq).
// Ports:
//   clk, reset (async, active-low)
//   mfc0, rd -> rdata      : combinational register read (0 when mfc0 low)
//   mtc0, rd, wdata        : register write
//   exception, pc, cause   : exception entry (EPC, Cause.ExcCode, Status push)
//   eret                   : exception return (Status pop)
//   status                 : current Status
//   exc_addr               : EPC during eret, otherwise EXC_VECTOR
//   timer_irq              : IP7 gated by IM7, IE and not EXL
module cp0_regs
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
   parameter logic [31:0] STATUS_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mfc0,
   input  logic        mtc0,
   input  logic [31:0] pc,
   input  logic [4:0]  rd,
   input  logic [31:0] wdata,
   input  logic        exception,
   input  logic        eret,
   input  logic [4:0]  cause,
   output logic [31:0] rdata,
   output logic [31:0] status,
   output logic [31:0] exc_addr,
   output logic        timer_irq
);

   logic [31:0] status_q;
   logic [31:0] cause_q;
   logic [31:0] cause_next;
   logic [31:0] epc_q;
   logic [31:0] count_val;
   logic [31:0] compare_val;
   logic        ip7_set;
   logic        ip7_clr;

   logic wr_status, wr_cause, wr_epc;
   assign wr_status = mtc0 && (rd == CP0_STATUS);
   assign wr_cause  = mtc0 && (rd == CP0_CAUSE);
   assign wr_epc    = mtc0 && (rd == CP0_EPC);

`ifdef CP0_TIMER_EN
   localparam bit TIMER_EN = 1'b1;
   logic wr_count, wr_compare, timer_match;
   assign wr_count   = mtc0 && (rd == CP0_COUNT);
   assign wr_compare = mtc0 && (rd == CP0_COMPARE);

   cp0_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .wr_count   (wr_count),
      .wr_compare (wr_compare),
      .wdata      (wdata),
      .count      (count_val),
      .compare    (compare_val),
      .match      (timer_match)
   );

   assign ip7_set   = timer_match;
   assign ip7_clr   = wr_compare;
   assign timer_irq = cause_q[CAUSE_IP7] & status_q[STATUS_IM7] &
                      status_q[STATUS_IE] & ~status_q[STATUS_EXL];
`else
   localparam bit TIMER_EN = 1'b0;
   assign count_val   = '0;
   assign compare_val = '0;
   assign ip7_set     = 1'b0;
   assign ip7_clr     = 1'b0;
   assign timer_irq   = 1'b0;
`endif

   // Exception owns Cause for the edge, so an mtc0 to Cause is dropped then.
   // IP7 is handled after the software write: a match sets it, and a
   // Compare write clears it even if a match lands on the same edge.
   always_comb begin
      cause_next = cause_q;
      if (exception)
         cause_next[6:2] = cause;
      else if (wr_cause)
         cause_next = wdata;
      if (ip7_set)
         cause_next[CAUSE_IP7] = 1'b1;
      if (ip7_clr)
         cause_next[CAUSE_IP7] = 1'b0;
      if (!TIMER_EN)
         cause_next[CAUSE_IP7] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         status_q <= STATUS_RESET;
         cause_q  <= '0;
         epc_q    <= '0;
      end else begin
         cause_q <= cause_next;
         if (exception) begin
            epc_q    <= pc;
            status_q <= status_q << 5;
         end else begin
            if (eret)
               status_q <= status_q >> 5;
            else if (wr_status)
               status_q <= wdata;
            if (wr_epc)
               epc_q <= wdata;
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (mfc0) begin
         case (rd)
            CP0_COUNT:   rdata = count_val;
            CP0_COMPARE: rdata = compare_val;
            CP0_STATUS:  rdata = status_q;
            CP0_CAUSE:   rdata = cause_q;
            CP0_EPC:     rdata = epc_q;
            default:     rdata = '0;
         endcase
      end
   end

   // eret has the final say on exc_addr even if exception is also high.
   assign exc_addr = eret ? epc_q : EXC_VECTOR;
   assign status   = status_q;

endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed and randomized checks of cp0_regs against a
// behavioural model of the CP0 register rules.
module tb_cp0_regs;
   import cp0_pkg::*;

   localparam logic [31:0] VEC = 32'h0040_0004;

   logic        clk = 1'b0;
   logic        reset, mfc0, mtc0, exception, eret, timer_irq;
   logic [31:0] pc, wdata, rdata, status, exc_addr;
   logic [4:0]  rd, cause;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;

   always #5 clk = ~clk;

   cp0_regs dut (
      .clk       (clk),
      .reset     (reset),
      .mfc0      (mfc0),
      .mtc0      (mtc0),
      .pc        (pc),
      .rd        (rd),
      .wdata     (wdata),
      .exception (exception),
      .eret      (eret),
      .cause     (cause),
      .rdata     (rdata),
      .status    (status),
      .exc_addr  (exc_addr),
      .timer_irq (timer_irq)
   );

   // The controller must never raise both strobes together.
   always @(posedge clk)
      if (reset === 1'b1 && exception === 1'b1 && eret === 1'b1)
         $error("exception and eret asserted together");

`ifdef CP0_TIMER_EN
   localparam bit HAS_TIMER = 1'b1;
`else
   localparam bit HAS_TIMER = 1'b0;
`endif

   function automatic logic [31:0] m_read(input logic [4:0] r);
      if (r == 5'd9  && HAS_TIMER) return m_count;
      if (r == 5'd11 && HAS_TIMER) return m_compare;
      if (r == 5'd12) return m_status;
      if (r == 5'd13) return m_cause;
      if (r == 5'd14) return m_epc;
      return 32'h0;
   endfunction

   function automatic logic m_irq();
      return m_cause[15] & m_status[15] & m_status[0] & ~m_status[1];
   endfunction

   task automatic m_reset();
      m_status = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
      m_count = 32'h0;  m_compare = 32'h0;
   endtask

   task automatic idle();
      mfc0 = 0; mtc0 = 0; exception = 0; eret = 0;
      rd = 0; wdata = 0; pc = 0; cause = 0;
   endtask

   // Advance one clock edge; the model applies the same-edge rules:
   // each register takes its highest-priority strobe (exception > eret > mtc0).
   task automatic step();
      logic [31:0] ns, nc, ne, ncnt, ncmp;
      logic        hit;
      ns = m_status; nc = m_cause; ne = m_epc; ncnt = m_count + 1; ncmp = m_compare;
      hit = (m_count == m_compare) && (m_compare != 0);
      if (exception) begin
         ne = pc;
         nc[6:2] = cause;
         ns = m_status << 5;
      end else if (eret) begin
         ns = m_status >> 5;
      end
      if (mtc0) begin
         if (rd == 5'd12 && !exception && !eret) ns = wdata;
         if (rd == 5'd13 && !exception) nc = wdata;
         if (rd == 5'd14 && !exception) ne = wdata;
         if (rd == 5'd9)  ncnt = wdata;
         if (rd == 5'd11) ncmp = wdata;
      end
      if (HAS_TIMER) begin
         if (hit) nc[15] = 1'b1;
         if (mtc0 && rd == 5'd11) nc[15] = 1'b0;
      end else begin
         nc[15] = 1'b0;
      end
      @(posedge clk); #1;
      m_status = ns; m_cause = nc; m_epc = ne; m_count = ncnt; m_compare = ncmp;
   endtask

   task automatic test_reset();
      mtc0 = 1; rd = 5'd12; wdata = 32'h0000_0005; step();
      rd = 5'd14; wdata = 32'h1234_5678; step();
      idle();
      #2 reset = 0;
      m_reset();
      #1;
      checks++;
      if (status !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=%h", status, 32'h0); end
      checks++;
      if (exc_addr !== VEC) begin failures++; $display("FAIL reset_exc_addr got=%h exp=%h", exc_addr, VEC); end
      checks++;
      if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
      mfc0 = 1;
      for (int r = 0; r < 32; r++) begin
         rd = r[4:0]; #1;
         checks++;
         if (rdata !== 32'h0) begin failures++; $display("FAIL reset_reg rd=%0d got=%h exp=0", r, rdata); end
      end
      idle();
      @(negedge clk) reset = 1;
      step();
      mfc0 = 1; rd = 5'd12; #1;
      checks++;
      if (rdata !== 32'h0) begin failures++; $display("FAIL post_reset_status got=%h exp=0", rdata); end
      idle();
   endtask

   task automatic test_mtc0_mfc0();
      mtc0 = 1; rd = CP0_STATUS; wdata = 32'h0000_0001; step();
      idle(); mfc0 = 1; rd = CP0_STATUS; #1;
      checks++;
      if (rdata !== 32'h1) begin failures++; $display("FAIL rt_rdata got=%h exp=1", rdata); end
      checks++;
      if (status !== 32'h1) begin failures++; $display("FAIL rt_status got=%h exp=1", status); end
      idle();
   endtask

   task automatic test_exception();
      exception = 1; cause = EXC_SYSCALL; pc = 32'h0040_0020; #1;
      checks++;
      if (exc_addr !== VEC) begin failures++; $display("FAIL exc_vector got=%h exp=%h", exc_addr, VEC); end
      step();
      idle(); mfc0 = 1; rd = CP0_EPC; #1;
      checks++;
      if (rdata !== 32'h0040_0020) begin failures++; $display("FAIL exc_epc got=%h exp=00400020", rdata); end
      rd = CP0_CAUSE; #1;
      checks++;
      if (rdata !== 32'h20) begin failures++; $display("FAIL exc_cause got=%h exp=20", rdata); end
      checks++;
      if (status !== 32'h20) begin failures++; $display("FAIL exc_status got=%h exp=20", status); end
      idle();
   endtask

   task automatic test_eret();
      eret = 1; #1;
      checks++;
      if (exc_addr !== 32'h0040_0020) begin failures++; $display("FAIL eret_addr got=%h exp=00400020", exc_addr); end
      step(); idle(); #1;
      checks++;
      if (status !== 32'h1) begin failures++; $display("FAIL eret_status got=%h exp=1", status); end
   endtask

   task automatic test_priority();
      exception = 1; cause = EXC_BREAK; pc = 32'h0040_0100;
      mtc0 = 1; rd = CP0_EPC; wdata = 32'hDEAD_BEEF;
      step(); idle(); mfc0 = 1; rd = CP0_EPC; #1;
      checks++;
      if (rdata !== 32'h0040_0100) begin failures++; $display("FAIL prio_epc got=%h exp=00400100", rdata); end
      // eret beats mtc0 on Status, but an EPC write in the same edge proceeds.
      idle(); eret = 1; mtc0 = 1; rd = CP0_STATUS; wdata = 32'hFFFF_0000;
      step(); idle(); #1;
      checks++;
      if (status !== 32'h1) begin failures++; $display("FAIL prio_eret_status got=%h exp=1", status); end
      mtc0 = 1; rd = CP0_EPC; wdata = 32'h0040_0200; eret = 1;
      step(); idle(); mfc0 = 1; rd = CP0_EPC; #1;
      checks++;
      if (rdata !== 32'h0040_0200) begin failures++; $display("FAIL prio_eret_epc got=%h exp=00400200", rdata); end
      checks++;
      if (status !== 32'h0) begin failures++; $display("FAIL prio_eret_pop got=%h exp=0", status); end
      idle();
   endtask

   task automatic test_back_to_back();
      mtc0 = 1; rd = CP0_STATUS; wdata = 32'h1; step();
      idle(); exception = 1; cause = EXC_TEQ; pc = 32'h0040_0300;
      step(); step(); idle(); #1;
      checks++;
      if (status !== 32'h400) begin failures++; $display("FAIL b2b_status got=%h exp=400", status); end
      eret = 1; step(); step(); idle(); #1;
      checks++;
      if (status !== 32'h1) begin failures++; $display("FAIL b2b_pop got=%h exp=1", status); end
   endtask

`ifdef CP0_TIMER_EN
   task automatic test_timer();
      mtc0 = 1; rd = CP0_STATUS;  wdata = 32'h8001; step();
      rd = CP0_COMPARE; wdata = 32'd10; step();
      rd = CP0_COUNT;   wdata = 32'd0;  step();
      idle();
      // Count reaches 10 after 10 edges; IP7 latches on the following edge.
      repeat (10) step();
      checks++;
      if (timer_irq !== 1'b0) begin failures++; $display("FAIL timer_early got=%b exp=0", timer_irq); end
      step();
      checks++;
      if (timer_irq !== 1'b1) begin failures++; $display("FAIL timer_fire got=%b exp=1", timer_irq); end
      repeat (3) step();
      checks++;
      if (timer_irq !== 1'b1) begin failures++; $display("FAIL timer_sticky got=%b exp=1", timer_irq); end
      mtc0 = 1; rd = CP0_COMPARE; wdata = 32'd20; step(); idle();
      checks++;
      if (timer_irq !== 1'b0) begin failures++; $display("FAIL timer_clear got=%b exp=0", timer_irq); end
      // Compare write on the same edge as a match: the clear wins.
      mtc0 = 1; rd = CP0_COUNT; wdata = 32'd19; step(); idle();
      step();
      mtc0 = 1; rd = CP0_COMPARE; wdata = 32'd20; step(); idle();
      checks++;
      if (timer_irq !== 1'b0) begin failures++; $display("FAIL timer_clr_wins got=%b exp=0", timer_irq); end
      step();
      checks++;
      if (timer_irq !== 1'b0) begin failures++; $display("FAIL timer_no_refire got=%b exp=0", timer_irq); end
   endtask
`else
   task automatic test_timer();
      mtc0 = 1; rd = 5'd9;  wdata = 32'h0000_0007; step();
      rd = 5'd11; wdata = 32'h0000_0009; step();
      rd = CP0_CAUSE; wdata = 32'hFFFF_FFFF; step();
      idle(); mfc0 = 1; rd = 5'd9; #1;
      checks++;
      if (rdata !== 32'h0) begin failures++; $display("FAIL notimer_count got=%h exp=0", rdata); end
      rd = 5'd11; #1;
      checks++;
      if (rdata !== 32'h0) begin failures++; $display("FAIL notimer_compare got=%h exp=0", rdata); end
      rd = CP0_CAUSE; #1;
      checks++;
      if (rdata !== 32'hFFFF_7FFF) begin failures++; $display("FAIL notimer_cause got=%h exp=ffff7fff", rdata); end
      checks++;
      if (timer_irq !== 1'b0) begin failures++; $display("FAIL notimer_irq got=%b exp=0", timer_irq); end
      idle(); mtc0 = 1; rd = CP0_CAUSE; wdata = 32'h0; step(); idle();
   endtask
`endif

   task automatic test_random();
      logic [4:0] picks [6];
      int sel;
      picks = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
      for (int it = 0; it < 400; it++) begin
         idle();
         sel = $urandom_range(0, 5);
         rd = (sel == 5) ? 5'($urandom) : picks[sel];
         mfc0 = $urandom_range(0, 3) != 0;
         mtc0 = $urandom_range(0, 2) == 0;
         wdata = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : $urandom;
         sel = $urandom_range(0, 9);
         exception = (sel == 0);
         eret = (sel == 1);
         pc = $urandom;
         cause = 5'($urandom);
         #1;
         checks++;
         if (rdata !== (mfc0 ? m_read(rd) : 32'h0)) begin
            failures++; $display("FAIL rand_rdata it=%0d rd=%0d got=%h exp=%h", it, rd, rdata, mfc0 ? m_read(rd) : 32'h0);
         end
         checks++;
         if (status !== m_status) begin failures++; $display("FAIL rand_status it=%0d got=%h exp=%h", it, status, m_status); end
         checks++;
         if (exc_addr !== (eret ? m_epc : VEC)) begin
            failures++; $display("FAIL rand_exc_addr it=%0d got=%h exp=%h", it, exc_addr, eret ? m_epc : VEC);
         end
         checks++;
         if (timer_irq !== m_irq()) begin failures++; $display("FAIL rand_irq it=%0d got=%b exp=%b", it, timer_irq, m_irq()); end
         step();
      end
      idle();
   endtask

   initial begin
      reset = 0;
      idle();
      m_reset();
      repeat (2) @(negedge clk);
      reset = 1;
      step();
      test_reset();
      test_mtc0_mfc0();
      test_exception();
      test_eret();
      test_priority();
      test_back_to_back();
      test_timer();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
